ps2_mouse_tracker: RTL and testbench

PS2_MOUSE_TRACKER -- requirements
Module: ps2_mouse_tracker

---
 rtl/ps2_mouse_tracker_if.sv | 21 ++
 rtl/ps2_mouse_tracker.sv | 126 ++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver and the resulting cursor/button state.
// The tracker consumes bytes through the slave modport.
interface ps2_mouse_tracker_if;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [7:0] x;
    logic [7:0] y;
    logic       left_click;
    logic       right_click;
    logic       packet_valid;

    modport master (
        output received_data, received_data_en,
        input  x, y, left_click, right_click, packet_valid
    );

    modport slave (
        input  received_data, received_data_en,
        output x, y, left_click, right_click, packet_valid
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Parses 3-byte PS/2 mouse packets and keeps a saturated cursor position
// plus button state. An idle watchdog resynchronises on a stalled packet.
module ps2_mouse_tracker #(
    parameter int X_MAX   = 159,
    parameter int Y_MAX   = 119,
    parameter int X_INIT  = 80,
    parameter int Y_INIT  = 60,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic               clock,
    input  logic               resetn,
    ps2_mouse_tracker_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {WAIT_HDR, WAIT_DX, WAIT_DY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    // Only the header bits that matter: {ovf_y, ovf_x, sign_y, sign_x, right, left}
    logic [5:0]       hdr_q, hdr_d;
    logic [7:0]       dx_q, dx_d;
    logic [7:0]       x_q, x_d, y_q, y_d;
    logic             left_q, left_d, right_q, right_d, pv_q, pv_d;

    logic               hdr_ok;
    logic               idle_expired;
    logic signed [10:0] dx_ext, dy_ext, x_sum, y_sum;

    function automatic logic [7:0] sat(input logic signed [10:0] v,
                                       input logic signed [10:0] vmax);
        if (v < 0)
            return 8'd0;
        else if (v > vmax)
            return 8'(vmax);
        else
            return v[7:0];
    endfunction

    assign hdr_ok = bus.received_data[3] && (bus.received_data != 8'hFA) &&
                    (bus.received_data != 8'hAA);
    assign idle_expired = (idle_q == CNT_W'(TIMEOUT - 1));

    // dy comes straight from the bus so the result lands on the third byte's edge
    assign dx_ext = {{3{hdr_q[2]}}, dx_q};
    assign dy_ext = {{3{hdr_q[3]}}, bus.received_data};
    assign x_sum  = $signed({3'b000, x_q}) + dx_ext;
    assign y_sum  = $signed({3'b000, y_q}) - dy_ext;

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        hdr_d   = hdr_q;
        dx_d    = dx_q;
        x_d     = x_q;
        y_d     = y_q;
        left_d  = left_q;
        right_d = right_q;
        pv_d    = 1'b0;
        case (state_q)
            WAIT_HDR: begin
                if (bus.received_data_en && hdr_ok) begin
                    hdr_d   = {bus.received_data[7:4], bus.received_data[1:0]};
                    state_d = WAIT_DX;
                end
            end
            WAIT_DX: begin
                if (bus.received_data_en) begin
                    dx_d    = bus.received_data;
                    state_d = WAIT_DY;
                end else if (idle_expired) begin
                    state_d = WAIT_HDR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            WAIT_DY: begin
                if (bus.received_data_en) begin
                    if (!hdr_q[4]) x_d = sat(x_sum, XMAX_S);
                    if (!hdr_q[5]) y_d = sat(y_sum, YMAX_S);
                    left_d  = hdr_q[0];
                    right_d = hdr_q[1];
                    pv_d    = 1'b1;
                    state_d = WAIT_HDR;
                end else if (idle_expired) begin
                    state_d = WAIT_HDR;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = WAIT_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= WAIT_HDR;
            idle_q  <= '0;
            hdr_q   <= '0;
            dx_q    <= '0;
            x_q     <= 8'(X_INIT);
            y_q     <= 8'(Y_INIT);
            left_q  <= 1'b0;
            right_q <= 1'b0;
            pv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            hdr_q   <= hdr_d;
            dx_q    <= dx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            left_q  <= left_d;
            right_q <= right_d;
            pv_q    <= pv_d;
        end
    end

    assign bus.x            = x_q;
    assign bus.y            = y_q;
    assign bus.left_click   = left_q;
    assign bus.right_click  = right_q;
    assign bus.packet_valid = pv_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed packet scenarios followed by randomized byte streams, every cycle
// checked against a packet-level reference model.
module tb_ps2_mouse_tracker;
    localparam int X_MAX   = 159;
    localparam int Y_MAX   = 119;
    localparam int X_INIT  = 80;
    localparam int Y_INIT  = 60;
    localparam int TIMEOUT = 40;

    logic clock;
    logic resetn;
    ps2_mouse_tracker_if bus();

    ps2_mouse_tracker #(
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int         mx, my, idle;
    logic       ml, mr, mpv;
    logic [7:0] pkt[$];

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_cycle(input logic rn, input logic en, input logic [7:0] d);
        logic [7:0] b0;
        int dx, dy;
        mpv = 1'b0;
        if (!rn) begin
            mx = X_INIT; my = Y_INIT; ml = 1'b0; mr = 1'b0;
            pkt.delete(); idle = 0;
        end else if (en) begin
            idle = 0;
            if (pkt.size() == 0) begin
                if (d[3] && d != 8'hFA && d != 8'hAA) pkt.push_back(d);
            end else begin
                pkt.push_back(d);
                if (pkt.size() == 3) begin
                    b0 = pkt[0];
                    dx = int'(pkt[1]); if (b0[4]) dx -= 256;
                    dy = int'(pkt[2]); if (b0[5]) dy -= 256;
                    if (!b0[6]) mx = clamp(mx + dx, X_MAX);
                    if (!b0[7]) my = clamp(my - dy, Y_MAX);
                    ml = b0[0]; mr = b0[1]; mpv = 1'b1;
                    pkt.delete();
                end
            end
        end else if (pkt.size() > 0) begin
            idle++;
            if (idle == TIMEOUT) begin
                pkt.delete();
                idle = 0;
            end
        end
    endtask

    task automatic step(input logic rn, input logic en, input logic [7:0] d);
        resetn = rn;
        bus.received_data_en = en;
        bus.received_data = d;
        @(posedge clock);
        #1;
        model_cycle(rn, en, d);
        chk("x", bus.x, 8'(mx));
        chk("y", bus.y, 8'(my));
        chk("left", {7'd0, bus.left_click}, {7'd0, ml});
        chk("right", {7'd0, bus.right_click}, {7'd0, mr});
        chk("pv", {7'd0, bus.packet_valid}, {7'd0, mpv});
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        step(1'b1, 1'b1, b0);
        step(1'b1, 1'b1, b1);
        step(1'b1, 1'b1, b2);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        resetn = 1'b0;
        bus.received_data_en = 1'b0;
        bus.received_data = 8'h00;

        do_reset();
        chk("rst_x", bus.x, 8'd80);
        chk("rst_y", bus.y, 8'd60);
        chk("rst_pv", {7'd0, bus.packet_valid}, 8'd0);

        send3(8'h09, 8'h05, 8'h03);
        chk("basic_x", bus.x, 8'd85);
        chk("basic_y", bus.y, 8'd57);
        chk("basic_left", {7'd0, bus.left_click}, 8'd1);
        chk("basic_right", {7'd0, bus.right_click}, 8'd0);
        chk("basic_pv", {7'd0, bus.packet_valid}, 8'd1);
        idle_n(1);
        chk("basic_pv_drop", {7'd0, bus.packet_valid}, 8'd0);

        do_reset();
        send3(8'h38, 8'h9C, 8'h9C);
        chk("sat_x", bus.x, 8'd0);
        chk("sat_y", bus.y, 8'd119);
        idle_n(2);

        do_reset();
        step(1'b1, 1'b1, 8'hFA);
        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b1, 8'h01);
        send3(8'h08, 8'h01, 8'h00);
        chk("ack_x", bus.x, 8'd81);
        chk("ack_y", bus.y, 8'd60);
        idle_n(2);

        do_reset();
        step(1'b1, 1'b1, 8'h08);
        step(1'b1, 1'b1, 8'h10);
        idle_n(TIMEOUT);
        send3(8'h08, 8'h02, 8'h00);
        chk("tmo_x", bus.x, 8'd82);
        chk("tmo_y", bus.y, 8'd60);

        // Strobe in the very cycle the watchdog would fire: byte is kept
        step(1'b1, 1'b1, 8'h08);
        step(1'b1, 1'b1, 8'h05);
        idle_n(TIMEOUT - 1);
        step(1'b1, 1'b1, 8'h00);
        chk("tmo_edge_x", bus.x, 8'd87);
        chk("tmo_edge_pv", {7'd0, bus.packet_valid}, 8'd1);

        do_reset();
        send3(8'h4A, 8'h7F, 8'h01);
        chk("ovf_x", bus.x, 8'd80);
        chk("ovf_y", bus.y, 8'd59);
        chk("ovf_right", {7'd0, bus.right_click}, 8'd1);

        // Reset mid-packet, with a strobe present during reset
        step(1'b1, 1'b1, 8'h08);
        step(1'b1, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h08);
        send3(8'h0B, 8'h00, 8'h00);
        chk("rstmid_x", bus.x, 8'd80);
        chk("rstmid_y", bus.y, 8'd60);
        chk("rstmid_left", {7'd0, bus.left_click}, 8'd1);
        chk("rstmid_right", {7'd0, bus.right_click}, 8'd1);

        // Back-to-back packets with no gap
        send3(8'h08, 8'h0A, 8'h00);
        send3(8'h28, 8'h00, 8'hF6);
        chk("b2b_x", bus.x, 8'd90);
        chk("b2b_y", bus.y, 8'd70);
        idle_n(1);

        for (int i = 0; i < 3000; i++) begin
            logic rn, en;
            logic [7:0] d;
            rn = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 2) != 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d[7:6] = 2'b00;
            if ($urandom_range(0, 2) == 0) d[3] = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                idle_n($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
            end
            step(rn, en, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
